mips_debug_ctrl: RTL and testbench

- Parametrised debug controller placed between the mips core and the unified mem on the top level.
- Owns the memory port: muxes it between the core and an external debug host.
- Adds halt/resume/single-step control, one PC breakpoint with re-trigger suppression, and a free-running execution-cycle counter.
- Generalises the passive check/checkm inspection path into an active host access path that can both read and write memory.

---
 rtl/mips_debug_ctrl.sv | 145 ++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// Debug controller between the mips core and unified memory: owns the memory port,
// adds halt/resume/step, one PC breakpoint, host memory access and a cycle counter.
module mips_debug_ctrl #(
   parameter int N            = 32,
   parameter int START_HALTED = 0,
   parameter int STEP_CYCLES  = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     cpu_adr,
   input  logic [N-1:0]     cpu_wdata,
   input  logic [1:0]       cpu_memwrite,
   input  logic [N-1:0]     cpu_pc,
   output logic             cpu_stall,
   output logic [N-1:0]     mem_adr,
   output logic [N-1:0]     mem_wdata,
   output logic [1:0]       mem_memwrite,
   input  logic [N-1:0]     mem_rdata,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             step,
   input  logic             bp_en,
   input  logic [N-1:0]     bp_pc,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [N-1:0]     dbg_adr,
   input  logic [N-1:0]     dbg_wdata,
   output logic             dbg_ack,
   output logic [N-1:0]     dbg_rdata,
   output logic             halted,
   output logic             bp_hit,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int SC_W = $clog2(STEP_CYCLES + 1);
   localparam logic [SC_W-1:0] STEP_LOAD = SC_W'(STEP_CYCLES);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_ACK  = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   localparam state_t RESET_STATE = (START_HALTED != 0) ? ST_HALT : ST_RUN;

   state_t           state_q, state_d;
   logic             skip_q, skip_d;
   logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
   logic             bp_hit_q, bp_hit_d;
   logic             halted_q, halted_d;
   logic             dbg_ack_q, dbg_ack_d;
   logic [N-1:0]     dbg_rdata_q, dbg_rdata_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic             bp_match;

   // skip masks the breakpoint while the multicycle core still sits on the PC we resumed from
   assign bp_match  = bp_en & (cpu_pc == bp_pc) & ~skip_q;
   assign cpu_stall = (state_q == ST_HALT) | (state_q == ST_ACK) |
                      ((state_q == ST_RUN) & (halt_req | bp_match));

   always_comb begin
      mem_adr      = cpu_adr;
      mem_wdata    = cpu_wdata;
      mem_memwrite = 2'b00;
      if (!cpu_stall) begin
         mem_memwrite = cpu_memwrite;
      end else if ((state_q == ST_HALT) && dbg_req) begin
         mem_adr      = dbg_adr;
         mem_wdata    = dbg_wdata;
         mem_memwrite = dbg_we ? 2'b01 : 2'b00;
      end
   end

   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      step_cnt_d  = step_cnt_q;
      bp_hit_d    = bp_hit_q;
      dbg_rdata_d = dbg_rdata_q;
      cycle_cnt_d = cpu_stall ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
      if (cpu_pc != bp_pc) skip_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (halt_req || bp_match) begin
               state_d = ST_HALT;
               if (bp_match) bp_hit_d = 1'b1;
            end
         end
         ST_HALT: begin
            if (dbg_req) begin
               if (!dbg_we) dbg_rdata_d = mem_rdata;
               state_d = ST_ACK;
            end else if (step) begin
               step_cnt_d = STEP_LOAD;
               bp_hit_d   = 1'b0;
               skip_d     = 1'b1;
               state_d    = ST_STEP;
            end else if (resume) begin
               bp_hit_d = 1'b0;
               skip_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_ACK: state_d = ST_HALT;
         ST_STEP: begin
            step_cnt_d = step_cnt_q - SC_W'(1);
            if (step_cnt_q <= SC_W'(1)) state_d = ST_HALT;
         end
         default: state_d = ST_HALT;
      endcase
      halted_d  = (state_d == ST_HALT) || (state_d == ST_ACK);
      dbg_ack_d = (state_d == ST_ACK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RESET_STATE;
         skip_q      <= 1'b0;
         step_cnt_q  <= '0;
         bp_hit_q    <= 1'b0;
         halted_q    <= (START_HALTED != 0);
         dbg_ack_q   <= 1'b0;
         dbg_rdata_q <= '0;
         cycle_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         step_cnt_q  <= step_cnt_d;
         bp_hit_q    <= bp_hit_d;
         halted_q    <= halted_d;
         dbg_ack_q   <= dbg_ack_d;
         dbg_rdata_q <= dbg_rdata_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign dbg_ack   = dbg_ack_q;
   assign dbg_rdata = dbg_rdata_q;
   assign halted    = halted_q;
   assign bp_hit    = bp_hit_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Bench for mips_debug_ctrl: table of per-cycle vectors plus directed sequences for
// host access passthrough, counter wrap and reset during an acknowledge.
module tb_mips_debug_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_adr, cpu_wdata, cpu_pc;
   logic [1:0]  cpu_memwrite;
   logic        cpu_stall;
   logic [31:0] mem_adr, mem_wdata, mem_rdata;
   logic [1:0]  mem_memwrite;
   logic        halt_req, resume, step, bp_en;
   logic [31:0] bp_pc;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_adr, dbg_wdata;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        halted, bp_hit;
   logic [3:0]  cycle_cnt;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_adr[7:2]];
   always @(posedge clk) begin
      if (mem_memwrite == 2'b01) mem[mem_adr[7:2]] <= mem_wdata;
   end

   mips_debug_ctrl #(
      .N(32), .START_HALTED(1), .STEP_CYCLES(4), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_memwrite(cpu_memwrite), .cpu_pc(cpu_pc),
      .cpu_stall(cpu_stall),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_memwrite(mem_memwrite), .mem_rdata(mem_rdata),
      .halt_req(halt_req), .resume(resume), .step(step), .bp_en(bp_en), .bp_pc(bp_pc),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .halted(halted), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
   );

   typedef struct {
      string       name;
      logic        halt_req, resume, step, dbg_req, dbg_we;
      logic [31:0] cpu_pc;
      logic [1:0]  cpu_mw;
      logic [31:0] dbg_adr, dbg_wdata;
      logic        x_stall;
      logic [1:0]  x_mw;
      logic        x_halted, x_bp_hit, x_ack;
      logic [31:0] x_rdata;
      logic [3:0]  x_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      halt_req     = v.halt_req;
      resume       = v.resume;
      step         = v.step;
      dbg_req      = v.dbg_req;
      dbg_we       = v.dbg_we;
      cpu_pc       = v.cpu_pc;
      cpu_memwrite = v.cpu_mw;
      dbg_adr      = v.dbg_adr;
      dbg_wdata    = v.dbg_wdata;
      @(negedge clk);
      chk({v.name, ".stall"}, 32'(cpu_stall), 32'(v.x_stall));
      chk({v.name, ".mem_memwrite"}, 32'(mem_memwrite), 32'(v.x_mw));
      @(posedge clk); #1;
      chk({v.name, ".halted"}, 32'(halted), 32'(v.x_halted));
      chk({v.name, ".bp_hit"}, 32'(bp_hit), 32'(v.x_bp_hit));
      chk({v.name, ".dbg_ack"}, 32'(dbg_ack), 32'(v.x_ack));
      chk({v.name, ".dbg_rdata"}, dbg_rdata, v.x_rdata);
      chk({v.name, ".cycle_cnt"}, 32'(cycle_cnt), 32'(v.x_cnt));
   endtask

   localparam logic [31:0] DB = 32'hDEADBEEF;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // name, halt_req, resume, step, dbg_req, dbg_we, cpu_pc, cpu_mw, dbg_adr, dbg_wdata,
      //   stall, mem_mw, halted, bp_hit, ack, rdata, cnt
      vecs.push_back(vec_t'{"dbg_wr",      0,0,0,1,1, 32'h00, 2'b01, 32'h20, DB, 1, 2'b01, 1,0,1, 32'h0, 4'd0});
      vecs.push_back(vec_t'{"ack_wr",      0,0,0,0,0, 32'h00, 2'b01, 32'h20, 0,  1, 2'b00, 1,0,0, 32'h0, 4'd0});
      vecs.push_back(vec_t'{"dbg_rd",      0,0,0,1,0, 32'h00, 2'b01, 32'h20, 0,  1, 2'b00, 1,0,1, DB, 4'd0});
      vecs.push_back(vec_t'{"ack_rd",      0,0,0,0,0, 32'h00, 2'b01, 32'h20, 0,  1, 2'b00, 1,0,0, DB, 4'd0});
      vecs.push_back(vec_t'{"rd_resume",   0,1,0,1,0, 32'h00, 2'b01, 32'h20, 0,  1, 2'b00, 1,0,1, DB, 4'd0});
      vecs.push_back(vec_t'{"ack_drop",    0,0,0,0,0, 32'h00, 2'b01, 32'h20, 0,  1, 2'b00, 1,0,0, DB, 4'd0});
      vecs.push_back(vec_t'{"resume",      0,1,0,0,0, 32'h00, 2'b01, 32'h20, 0,  1, 2'b00, 0,0,0, DB, 4'd0});
      vecs.push_back(vec_t'{"run_pc04",    0,0,0,0,0, 32'h04, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd1});
      vecs.push_back(vec_t'{"bp_arrive",   0,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 1,1,0, DB, 4'd1});
      vecs.push_back(vec_t'{"bp_hold",     0,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 1,1,0, DB, 4'd1});
      vecs.push_back(vec_t'{"resume_bp",   0,1,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 0,0,0, DB, 4'd1});
      vecs.push_back(vec_t'{"skip_1",      0,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd2});
      vecs.push_back(vec_t'{"skip_2",      0,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd3});
      vecs.push_back(vec_t'{"pc_moves",    0,0,0,0,0, 32'h10, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd4});
      vecs.push_back(vec_t'{"bp_and_halt", 1,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 1,1,0, DB, 4'd4});
      vecs.push_back(vec_t'{"step",        0,0,1,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 0,0,0, DB, 4'd4});
      vecs.push_back(vec_t'{"step_c1",     1,0,0,0,0, 32'h10, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd5});
      vecs.push_back(vec_t'{"step_c2",     1,0,1,0,0, 32'h0C, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd6});
      vecs.push_back(vec_t'{"step_c3",     0,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd7});
      vecs.push_back(vec_t'{"step_c4",     0,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  0, 2'b01, 1,0,0, DB, 4'd8});
      vecs.push_back(vec_t'{"post_step",   0,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 1,0,0, DB, 4'd8});
      vecs.push_back(vec_t'{"resume_hr",   1,1,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 0,0,0, DB, 4'd8});
      vecs.push_back(vec_t'{"run_resume",  0,1,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  0, 2'b01, 0,0,0, DB, 4'd9});
      vecs.push_back(vec_t'{"hr_rehalt",   1,0,0,0,0, 32'h0C, 2'b01, 32'h20, 0,  1, 2'b00, 1,0,0, DB, 4'd9});

      reset = 1'b1; halt_req = 0; resume = 0; step = 0;
      bp_en = 1'b1; bp_pc = 32'h0C;
      cpu_adr = 32'h100; cpu_wdata = 32'h55; cpu_pc = 32'h0; cpu_memwrite = 2'b00;
      dbg_req = 0; dbg_we = 0; dbg_adr = 32'h0; dbg_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst.halted", 32'(halted), 32'd1);
      chk("rst.bp_hit", 32'(bp_hit), 32'd0);
      chk("rst.dbg_ack", 32'(dbg_ack), 32'd0);
      chk("rst.dbg_rdata", dbg_rdata, 32'd0);
      chk("rst.cycle_cnt", 32'(cycle_cnt), 32'd0);
      chk("rst.stall", 32'(cpu_stall), 32'd1);

      foreach (vecs[i]) apply(vecs[i]);

      // host write path drives the memory port; readback through the same path
      halt_req = 0; resume = 0; step = 0;
      dbg_req = 1; dbg_we = 1; dbg_adr = 32'h24; dbg_wdata = 32'h12345678;
      @(negedge clk);
      chk("hw.mem_adr", mem_adr, 32'h24);
      chk("hw.mem_wdata", mem_wdata, 32'h12345678);
      chk("hw.mem_memwrite", 32'(mem_memwrite), 32'h1);
      @(posedge clk); #1;
      chk("hw.ack", 32'(dbg_ack), 32'd1);
      dbg_req = 0;
      @(posedge clk); #1;
      chk("hw.ack_clear", 32'(dbg_ack), 32'd0);
      dbg_req = 1; dbg_we = 0;
      @(posedge clk); #1;
      chk("hr.ack", 32'(dbg_ack), 32'd1);
      chk("hr.rdata", dbg_rdata, 32'h12345678);
      dbg_req = 0;
      @(posedge clk); #1;
      resume = 1;
      @(posedge clk); #1;
      resume = 0; cpu_pc = 32'h40; cpu_adr = 32'h80; cpu_wdata = 32'hCAFEF00D; cpu_memwrite = 2'b10;
      @(negedge clk);
      chk("run.stall", 32'(cpu_stall), 32'd0);
      chk("run.mem_adr", mem_adr, 32'h80);
      chk("run.mem_wdata", mem_wdata, 32'hCAFEF00D);
      chk("run.mem_memwrite", 32'(mem_memwrite), 32'h2);

      // 17 unstalled cycles on a 4-bit counter wrap to 1
      reset = 1;
      @(posedge clk); #1;
      reset = 0; cpu_memwrite = 2'b00;
      chk("wrap.start_cnt", 32'(cycle_cnt), 32'd0);
      chk("wrap.start_halted", 32'(halted), 32'd1);
      resume = 1;
      @(posedge clk); #1;
      resume = 0;
      repeat (17) @(posedge clk);
      #1;
      chk("wrap.cnt", 32'(cycle_cnt), 32'd1);
      halt_req = 1;
      @(posedge clk); #1;
      halt_req = 0;
      chk("wrap.halted", 32'(halted), 32'd1);
      chk("wrap.cnt_held", 32'(cycle_cnt), 32'd1);

      // reset in the middle of an acknowledge cycle aborts it
      dbg_req = 1; dbg_we = 0; dbg_adr = 32'h24;
      @(posedge clk); #1;
      chk("rack.ack", 32'(dbg_ack), 32'd1);
      chk("rack.rdata", dbg_rdata, 32'h12345678);
      reset = 1; dbg_req = 0;
      @(posedge clk); #1;
      reset = 0;
      chk("rack.ack_abort", 32'(dbg_ack), 32'd0);
      chk("rack.halted", 32'(halted), 32'd1);
      chk("rack.rdata", dbg_rdata, 32'd0);
      chk("rack.cnt", 32'(cycle_cnt), 32'd0);
      @(posedge clk); #1;
      chk("rack.no_late_ack", 32'(dbg_ack), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
